// File: rtl/pll_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_pkg;

    // Encodings are visible on state_o, so they are fixed explicitly.
    typedef enum logic [1:0] {
        StPllRst   = 2'd0,
        StWaitLock = 2'd1,
        StRelease  = 2'd2,
        StRun      = 2'd3
    } pll_state_e;

    localparam int unsigned DefRstCycles     = 16;
    localparam int unsigned DefStableCycles  = 1024;
    localparam int unsigned DefTimeoutCycles = 65536;
    localparam int unsigned DefReleaseCycles = 64;
    localparam int unsigned DefCntW          = 8;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-low clear to zero.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and system reset release sequencer on the reference clock.
module pll_reset_sequencer
    import pll_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = DefRstCycles,
    parameter int unsigned STABLE_CYCLES  = DefStableCycles,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
    parameter int unsigned RELEASE_CYCLES = DefReleaseCycles,
    parameter int unsigned CNT_W          = DefCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]       state_o
);

    // One shared cycle counter, sized for the longest per-state limit.
    localparam int unsigned CycLimit =
        (TIMEOUT_CYCLES > RST_CYCLES) ?
            ((TIMEOUT_CYCLES > RELEASE_CYCLES) ? TIMEOUT_CYCLES : RELEASE_CYCLES) :
            ((RST_CYCLES > RELEASE_CYCLES) ? RST_CYCLES : RELEASE_CYCLES);
    localparam int unsigned CycW  = clog2_min1(CycLimit);
    localparam int unsigned StabW = clog2_min1(STABLE_CYCLES);

    localparam logic [CycW-1:0]  RstLast     = CycW'(RST_CYCLES - 1);
    localparam logic [CycW-1:0]  TimeoutLast = CycW'(TIMEOUT_CYCLES - 1);
    localparam logic [CycW-1:0]  RelLast     = CycW'(RELEASE_CYCLES - 1);
    localparam logic [StabW-1:0] StabLast    = StabW'(STABLE_CYCLES - 1);

    pll_state_e       state_q, state_d;
    logic [CycW-1:0]  cyc_q, cyc_d;
    logic [StabW-1:0] stab_q, stab_d;
    logic [CNT_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             ready_q, ready_d;
    logic             locked_s;

    sync_2ff #(
        .Width (1)
    ) u_lock_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPllRst;
            cyc_q       <= '0;
            stab_q      <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stab_q      <= stab_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
        end
    end

    // Next state, counter updates and saturating event counts.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + 1'b1;
        stab_d  = '0;
        retry_d = retry_q;
        loss_d  = loss_q;
        unique case (state_q)
            StPllRst: begin
                if (cyc_q == RstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                stab_d = locked_s ? stab_q + 1'b1 : '0;
                // Qualification takes priority over a coincident timeout.
                if (locked_s && (stab_q == StabLast)) begin
                    state_d = StRelease;
                end else if (cyc_q == TimeoutLast) begin
                    state_d = StPllRst;
                    if (retry_q != '1) retry_d = retry_q + 1'b1;
                end
            end
            StRelease: begin
                if (!locked_s) begin
                    state_d = StPllRst;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end else if (cyc_q == RelLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cyc_d = cyc_q;
                if (!locked_s) begin
                    state_d = StPllRst;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end
            end
            default: state_d = StPllRst;
        endcase
        if (state_d != state_q) begin
            cyc_d  = '0;
            stab_d = '0;
        end
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        pll_rst_d   = (state_d == StPllRst);
        sys_rst_n_d = (state_d == StRun);
        ready_d     = (state_d == StRun);
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst_n     = sys_rst_n_q;
    assign ready         = ready_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with shortened timing.
module tb_pll_reset_sequencer;

    localparam int unsigned RstC = 4;
    localparam int unsigned StbC = 8;
    localparam int unsigned ToC  = 32;
    localparam int unsigned RelC = 4;
    localparam int unsigned CntW = 3;
    localparam int MaxWait = 200;

    logic            clk;
    logic            rst_n;
    logic            pll_locked;
    logic            pll_rst;
    logic            sys_rst_n;
    logic            ready;
    logic [CntW-1:0] retry_cnt;
    logic [CntW-1:0] lock_loss_cnt;
    logic [1:0]      state_o;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks;
    int   errors;
    int   n;
    logic watch_sys;
    logic sys_seen;

    pll_reset_sequencer #(
        .RST_CYCLES     (RstC),
        .STABLE_CYCLES  (StbC),
        .TIMEOUT_CYCLES (ToC),
        .RELEASE_CYCLES (RelC),
        .CNT_W          (CntW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags any cycle where sys_rst_n is released while watching.
    always @(negedge clk) begin
        if (!watch_sys) sys_seen = 1'b0;
        else if (sys_rst_n === 1'b1) sys_seen = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges until the selected output equals val; -1 if the bound expires.
    task automatic edges_until(input int sel, input int val, output int cnt);
        int cur;
        cnt = -1;
        for (int i = 1; i <= MaxWait; i++) begin
            tick();
            case (sel)
                0:       cur = int'(pll_rst);
                1:       cur = int'(sys_rst_n);
                2:       cur = int'(ready);
                default: cur = int'(state_o);
            endcase
            if (cur == val) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic apply_reset(input logic lock);
        rst_n      = 1'b0;
        pll_locked = lock;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        pll_locked = 1'b1;
        rst_n      = 1'b0;
        tick();
        tick();
        checks++;
        if (state_o !== 2'd0 || pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got state=%0d pll_rst=%b sys_rst_n=%b ready=%b, expected 0 1 0 0",
                     state_o, pll_rst, sys_rst_n, ready);
        end
        checks++;
        if (retry_cnt !== 3'd0 || lock_loss_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_counts: got retry=%0d loss=%0d, expected 0 0", retry_cnt, lock_loss_cnt);
        end
        exp_q.push_back('{"pll_rst_high_edges", RstC});
        exp_q.push_back('{"wait_to_run_edges", StbC + RelC});
        rst_n = 1'b1;
        edges_until(0, 0, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", e.tag, n, e.val);
        end
        edges_until(1, 1, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", e.tag, n, e.val);
        end
        checks++;
        if (ready !== 1'b1 || state_o !== 2'd3 || retry_cnt !== 3'd0 || lock_loss_cnt !== 3'd0) begin
            errors++;
            $display("FAIL run_state: got ready=%b state=%0d retry=%0d loss=%0d, expected 1 3 0 0",
                     ready, state_o, retry_cnt, lock_loss_cnt);
        end
    endtask

    task automatic test_lock_loss();
        exp_q.push_back('{"drop_to_sys_rst_edges", 3});
        exp_q.push_back('{"resequence_pll_rst_edges", RstC});
        exp_q.push_back('{"resequence_wait_to_run_edges", StbC + RelC});
        pll_locked = 1'b0;
        edges_until(1, 0, n);
        pll_locked = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (n !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", e.tag, n, e.val);
        end
        checks++;
        if (ready !== 1'b0 || state_o !== 2'd0 || pll_rst !== 1'b1 || lock_loss_cnt !== 3'd1) begin
            errors++;
            $display("FAIL lock_drop_state: got ready=%b state=%0d pll_rst=%b loss=%0d, expected 0 0 1 1",
                     ready, state_o, pll_rst, lock_loss_cnt);
        end
        edges_until(0, 0, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", e.tag, n, e.val);
        end
        edges_until(1, 1, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", e.tag, n, e.val);
        end
        checks++;
        if (ready !== 1'b1 || lock_loss_cnt !== 3'd1 || retry_cnt !== 3'd0) begin
            errors++;
            $display("FAIL rerun_state: got ready=%b loss=%0d retry=%0d, expected 1 1 0",
                     ready, lock_loss_cnt, retry_cnt);
        end
    endtask

    task automatic test_async_reset();
        // One-cycle lock glitch in RUN makes the counts non-zero first.
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        edges_until(3, 2, n);
        checks++;
        if (n < 0 || lock_loss_cnt !== 3'd2) begin
            errors++;
            $display("FAIL reach_release: got edges=%0d loss=%0d, expected edges>=0 loss=2",
                     n, lock_loss_cnt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || state_o !== 2'd0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_outputs: got pll_rst=%b sys_rst_n=%b state=%0d ready=%b, expected 1 0 0 0",
                     pll_rst, sys_rst_n, state_o, ready);
        end
        checks++;
        if (retry_cnt !== 3'd0 || lock_loss_cnt !== 3'd0) begin
            errors++;
            $display("FAIL async_reset_counts: got retry=%0d loss=%0d, expected 0 0",
                     retry_cnt, lock_loss_cnt);
        end
        #4;
        rst_n = 1'b1;
    endtask

    task automatic test_timeout_saturate();
        watch_sys = 1'b0;
        apply_reset(1'b0);
        watch_sys = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back('{"attempt_pll_rst_high", RstC});
            exp_q.push_back('{"attempt_pll_rst_low", ToC});
            exp_q.push_back('{"retry_cnt", (i > 7) ? 7 : i});
        end
        for (int i = 1; i <= 8; i++) begin
            edges_until(0, 0, n);
            e = exp_q.pop_front();
            checks++;
            if (n !== e.val) begin
                errors++;
                $display("FAIL %s[%0d]: got %0d, expected %0d", e.tag, i, n, e.val);
            end
            edges_until(0, 1, n);
            e = exp_q.pop_front();
            checks++;
            if (n !== e.val) begin
                errors++;
                $display("FAIL %s[%0d]: got %0d, expected %0d", e.tag, i, n, e.val);
            end
            e = exp_q.pop_front();
            checks++;
            if (int'(retry_cnt) !== e.val) begin
                errors++;
                $display("FAIL %s[%0d]: got %0d, expected %0d", e.tag, i, retry_cnt, e.val);
            end
        end
        checks++;
        if (sys_seen !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sys_rst_n: got released=%b, expected 0", sys_seen);
        end
        watch_sys = 1'b0;
    endtask

    task automatic test_toggle();
        int cnt;
        apply_reset(1'b0);
        edges_until(0, 0, n);
        checks++;
        if (n !== int'(RstC)) begin
            errors++;
            $display("FAIL toggle_entry: got %0d, expected %0d", n, RstC);
        end
        exp_q.push_back('{"toggle_timeout_edges", ToC});
        exp_q.push_back('{"toggle_retry_cnt", 1});
        watch_sys = 1'b1;
        cnt = -1;
        // High five cycles, low one: stab never reaches eight.
        for (int i = 0; i < 60; i++) begin
            pll_locked = ((i % 6) != 5);
            tick();
            if (pll_rst === 1'b1) begin
                cnt = i + 1;
                break;
            end
        end
        pll_locked = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (cnt !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", e.tag, cnt, e.val);
        end
        e = exp_q.pop_front();
        checks++;
        if (int'(retry_cnt) !== e.val || sys_seen !== 1'b0) begin
            errors++;
            $display("FAIL %s: got %0d (sys released=%b), expected %0d", e.tag, retry_cnt, sys_seen, e.val);
        end
        watch_sys = 1'b0;
    endtask

    task automatic test_align();
        // Continues from the previous timeout with retry_cnt at one.
        edges_until(0, 0, n);
        exp_q.push_back('{"align_edges_to_release", 10});
        exp_q.push_back('{"align_retry_cnt", 1});
        exp_q.push_back('{"align_release_to_run", RelC});
        repeat (22) tick();
        pll_locked = 1'b1;
        edges_until(3, 2, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", e.tag, n, e.val);
        end
        e = exp_q.pop_front();
        checks++;
        if (int'(retry_cnt) !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", e.tag, retry_cnt, e.val);
        end
        edges_until(3, 3, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e.val || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: got %0d (ready=%b), expected %0d", e.tag, n, ready, e.val);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        watch_sys  = 1'b0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        test_reset();
        test_lock_loss();
        test_async_reset();
        test_timeout_saturate();
        test_toggle();
        test_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
